// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : key_debouncer
//  Description : Conditions raw active-low push-button pins. Each key is
//                synchronised into the Clock domain through two flops, then
//                inverted to active-high and filtered for contact bounce.
//                The output stage gives a clean level, a one-cycle press
//                pulse and a one-cycle release pulse for every key.
//  Ports       : Clock_i          system clock
//                Reset_i          synchronous, active-high reset
//                Key_n_i          raw asynchronous key pins (0 = pressed)
//                Pressed_o        debounced level (1 = held)
//                Press_pulse_o    one-cycle pulse when Pressed rises
//                Release_pulse_o  one-cycle pulse when Pressed falls
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer #(
   parameter int NUM_KEYS        = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                Clock_i,
   input  logic                Reset_i,
   input  logic [NUM_KEYS-1:0] Key_n_i,
   output logic [NUM_KEYS-1:0] Pressed_o,
   output logic [NUM_KEYS-1:0] Press_pulse_o,
   output logic [NUM_KEYS-1:0] Release_pulse_o
);

   // Count value at which a differing sample has been stable long enough.
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Two-flop synchroniser. Both stages reset to the released pin level so
   // that the internal sample reads "not pressed" straight out of reset.
   logic [NUM_KEYS-1:0] sync1_q;
   logic [NUM_KEYS-1:0] sync2_q;
   logic [NUM_KEYS-1:0] sample_w;

   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= Key_n_i;
         sync2_q <= sync1_q;
      end
   end

   // Active-high view of the synchronised pin.
   assign sample_w = ~sync2_q;

   generate
      for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic             stable_q;
         logic             stable_d;
         logic             press_q;
         logic             press_d;
         logic             release_q;
         logic             release_d;

         // Any sample equal to the accepted level clears the count, so a
         // bounce restarts the qualification from zero. The counter stops
         // at C_CNT_LAST, where the new level is accepted and the count is
         // cleared, so it can never wrap.
         always_comb begin
            cnt_d     = '0;
            stable_d  = stable_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sample_w[k] != stable_q) begin
               if (cnt_q == C_CNT_LAST) begin
                  stable_d  = sample_w[k];
                  press_d   = sample_w[k];
                  release_d = ~sample_w[k];
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         always_ff @(posedge Clock_i) begin
            if (Reset_i) begin
               cnt_q     <= '0;
               stable_q  <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
            end else begin
               cnt_q     <= cnt_d;
               stable_q  <= stable_d;
               press_q   <= press_d;
               release_q <= release_d;
            end
         end

         assign Pressed_o[k]       = stable_q;
         assign Press_pulse_o[k]   = press_q;
         assign Release_pulse_o[k] = release_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debouncer
//  Description : Directed, table-driven bench for key_debouncer with
//                DEBOUNCE_CYCLES = 8 (pin-to-output latency of 10 edges),
//                plus hand-written bounce and mid-debounce reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debouncer;

   localparam int NUM_KEYS        = 3;
   localparam int DEBOUNCE_CYCLES = 8;
   localparam int CNT_W           = 4;

   logic                clk;
   logic                rst;
   logic [NUM_KEYS-1:0] key_n;
   logic [NUM_KEYS-1:0] pressed;
   logic [NUM_KEYS-1:0] press_pulse;
   logic [NUM_KEYS-1:0] release_pulse;

   int n_checks;
   int n_fail;

   key_debouncer #(
      .NUM_KEYS       (NUM_KEYS),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) dut (
      .Clock_i        (clk),
      .Reset_i        (rst),
      .Key_n_i        (key_n),
      .Pressed_o      (pressed),
      .Press_pulse_o  (press_pulse),
      .Release_pulse_o(release_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic [2:0] key;
      logic [2:0] ep;
      logic [2:0] epp;
      logic [2:0] erp;
   } vec_t;

   vec_t tbl[$];

   // Append n identical one-cycle vectors.
   task automatic add(input int n, input logic r, input logic [2:0] k,
                      input logic [2:0] ep, input logic [2:0] epp,
                      input logic [2:0] erp);
      vec_t v;
      v.rst = r;
      v.key = k;
      v.ep  = ep;
      v.epp = epp;
      v.erp = erp;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   // Inputs are driven 1 time unit after a rising edge; outputs are
   // sampled 1 time unit after the following rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [8:0] act,
                        input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: {pressed,press,release} got %b_%b_%b required %b_%b_%b",
                  name, act[8:6], act[5:3], act[2:0], exp[8:6], exp[5:3], exp[2:0]);
      end
   endtask

   function automatic logic [8:0] outs();
      return {pressed, press_pulse, release_pulse};
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      key_n    = 3'b111;

      // ---------------- vector table ----------------
      // reset state
      add(2, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
      // clean press of key 1: accepted on the 10th edge
      add(9, 1'b0, 3'b101, 3'b000, 3'b000, 3'b000);
      add(1, 1'b0, 3'b101, 3'b010, 3'b010, 3'b000);
      add(3, 1'b0, 3'b101, 3'b010, 3'b000, 3'b000);
      // release of key 1
      add(9, 1'b0, 3'b111, 3'b010, 3'b000, 3'b000);
      add(1, 1'b0, 3'b111, 3'b000, 3'b000, 3'b010);
      add(2, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
      // short glitch on key 1: 7 cycles low is one short of acceptance
      add(7, 1'b0, 3'b101, 3'b000, 3'b000, 3'b000);
      add(12, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
      // press then release of key 2
      add(9, 1'b0, 3'b011, 3'b000, 3'b000, 3'b000);
      add(1, 1'b0, 3'b011, 3'b100, 3'b100, 3'b000);
      add(2, 1'b0, 3'b011, 3'b100, 3'b000, 3'b000);
      add(9, 1'b0, 3'b111, 3'b100, 3'b000, 3'b000);
      add(1, 1'b0, 3'b111, 3'b000, 3'b000, 3'b100);
      add(2, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
      // all keys together
      add(9, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
      add(1, 1'b0, 3'b000, 3'b111, 3'b111, 3'b000);
      add(2, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000);
      add(9, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000);
      add(1, 1'b0, 3'b111, 3'b000, 3'b000, 3'b111);
      add(2, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
      // exactly 8 low cycles on key 0 is just long enough
      add(8, 1'b0, 3'b110, 3'b000, 3'b000, 3'b000);
      add(1, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
      add(1, 1'b0, 3'b111, 3'b001, 3'b001, 3'b000);
      add(7, 1'b0, 3'b111, 3'b001, 3'b000, 3'b000);
      add(1, 1'b0, 3'b111, 3'b000, 3'b000, 3'b001);
      add(2, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);

      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         rst   = tbl[i].rst;
         key_n = tbl[i].key;
         tick();
         check($sformatf("vec%0d", i), outs(),
               {tbl[i].ep, tbl[i].epp, tbl[i].erp});
      end

      // ---------------- bounce on key 0 ----------------
      for (int i = 0; i < 30; i++) begin
         key_n = (((i / 3) % 2) == 0) ? 3'b110 : 3'b111;
         tick();
         check($sformatf("bounce%0d", i), outs(), 9'b000_000_000);
      end
      key_n = 3'b110;
      for (int e = 1; e <= 9; e++) begin
         tick();
         check($sformatf("settle_e%0d", e), outs(), 9'b000_000_000);
      end
      tick();
      check("settle_e10", outs(), 9'b001_001_000);
      tick();
      check("settle_e11", outs(), 9'b001_000_000);
      key_n = 3'b111;
      for (int e = 1; e <= 9; e++) tick();
      tick();
      check("bounce_release", outs(), 9'b000_000_001);
      tick();
      check("bounce_idle", outs(), 9'b000_000_000);

      // ---------------- reset mid-debounce ----------------
      key_n = 3'b110;
      for (int e = 1; e <= 7; e++) begin
         tick();
         check($sformatf("pre_rst_e%0d", e), outs(), 9'b000_000_000);
      end
      rst = 1'b1;
      tick();
      check("mid_rst", outs(), 9'b000_000_000);
      rst = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         tick();
         check($sformatf("post_rst_e%0d", e), outs(), 9'b000_000_000);
      end
      tick();
      check("post_rst_e10", outs(), 9'b001_001_000);
      tick();
      check("post_rst_e11", outs(), 9'b001_000_000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
